// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM 5-stage pipeline hazard/forwarding
// controller.
//   sb_entry_t      : one in-flight writer tracked by the scoreboard
//   FWD_RF          : fwd_sel code meaning "use the ID/EXE register value"
//   *_legal()       : parameter range checks, evaluated at elaboration
package arm_pipe_pkg;

  // Widest register address the scoreboard entry can hold; narrower
  // addresses are zero-extended on entry.
  localparam int unsigned SB_DEST_W = 8;

  localparam int unsigned FWD_RF = 0;

  typedef struct packed {
    logic                 valid;
    logic                 wb_en;
    logic [SB_DEST_W-1:0] dest;
    logic                 is_load;
  } sb_entry_t;

  function automatic bit depth_legal(input int unsigned depth);
    return depth >= 2;
  endfunction

  // LOAD_LAT < DEPTH-1, written without subtraction to avoid underflow.
  function automatic bit load_lat_legal(input int unsigned load_lat,
                                        input int unsigned depth);
    return (load_lat + 1) < depth;
  endfunction

  function automatic bit addr_w_legal(input int unsigned addr_w);
    return (addr_w >= 1) && (addr_w <= SB_DEST_W);
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Shift-register scoreboard of in-flight writers behind ID, with a
// youngest-match priority encoder for two source operands.
//   clk_i, rst_i   : clock, synchronous active-high reset (clears all entries)
//   adv_i          : shift enable; entry 0 <- push_i, entry k <- entry k-1
//   push_i         : entry describing the instruction leaving ID
//   src_a/b_i      : source register addresses to look up
//   hit_a/b_o      : a valid writer of that register is in flight
//   idx_a/b_o      : index k of the youngest matching entry
//   load_a/b_o     : that matching writer is a load
module pipe_scoreboard
  import arm_pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned DEPTH      = 3,
  localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  adv_i,
  input  sb_entry_t             push_i,
  input  logic [REG_ADDR_W-1:0] src_a_i,
  input  logic [REG_ADDR_W-1:0] src_b_i,
  output logic                  hit_a_o,
  output logic [IDX_W-1:0]      idx_a_o,
  output logic                  load_a_o,
  output logic                  hit_b_o,
  output logic [IDX_W-1:0]      idx_b_o,
  output logic                  load_b_o
);

  // The WB entry (DEPTH-1) is never matched because the register file is
  // write-first, so only entries 0..DEPTH-2 are stored.
  localparam int unsigned NMATCH = DEPTH - 1;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
    logic             load;
  } match_t;

  sb_entry_t sb_q [NMATCH];
  sb_entry_t sb_d [NMATCH];
  match_t    match_a, match_b;

  function automatic match_t find_youngest(input logic [REG_ADDR_W-1:0] src,
                                           input sb_entry_t sb [NMATCH]);
    match_t m;
    m = '0;
    for (int unsigned k = 0; k < NMATCH; k++) begin
      if (!m.hit && sb[k].valid && sb[k].wb_en &&
          (sb[k].dest == SB_DEST_W'(src))) begin
        m.hit  = 1'b1;
        m.idx  = IDX_W'(k);
        m.load = sb[k].is_load;
      end
    end
    return m;
  endfunction

  always_comb begin
    sb_d = sb_q;
    if (adv_i) begin
      sb_d[0] = push_i;
      for (int unsigned k = 1; k < NMATCH; k++) begin
        sb_d[k] = sb_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < NMATCH; k++) begin
      if (rst_i) sb_q[k] <= '0;
      else       sb_q[k] <= sb_d[k];
    end
  end

  always_comb begin
    match_a = find_youngest(src_a_i, sb_q);
    match_b = find_youngest(src_b_i, sb_q);
  end

  assign hit_a_o  = match_a.hit;
  assign idx_a_o  = match_a.idx;
  assign load_a_o = match_a.load;
  assign hit_b_o  = match_b.hit;
  assign idx_b_o  = match_b.idx;
  assign load_b_o = match_b.load;

endmodule

// File: rtl/pipe_hazard_fwd_ctrl.sv
// Hazard, forwarding and flush controller for the ARM 5-stage pipeline.
// Sits beside ID; drives IF/ID freeze/flush, ID/EXE flush and EXE operand muxes.
//   clk, rst                    : clock, synchronous active-high reset
//   id_*                        : description of the instruction in ID
//   br_taken                    : branch resolved taken in EXE
//   mem_busy                    : data memory wait, whole pipeline freezes
//   freeze_all                  : hold every pipeline register
//   stall_if                    : hold PC and IF/ID, bubble into ID/EXE
//   flush_if_id, flush_id_exe   : clear IF/ID and ID/EXE
//   fwd_sel_a/b                 : registered EXE operand source (0 = ID/EXE value)
//   stall_cnt/flush_cnt/freeze_cnt : saturating event counters
module pipe_hazard_fwd_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned DEPTH      = 3,
  parameter bit          FWD_EN     = 1'b1,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned FWD_SEL_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_use_src1,
  input  logic                  id_use_src2,
  input  logic                  id_wb_en,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_mem_r_en,
  input  logic                  br_taken,
  input  logic                  mem_busy,
  output logic                  freeze_all,
  output logic                  stall_if,
  output logic                  flush_if_id,
  output logic                  flush_id_exe,
  output logic [FWD_SEL_W-1:0]  fwd_sel_a,
  output logic [FWD_SEL_W-1:0]  fwd_sel_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      freeze_cnt
);

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("pipe_hazard_fwd_ctrl: DEPTH must be >= 2");
  end
  if (!load_lat_legal(LOAD_LAT, DEPTH)) begin : g_bad_load_lat
    $error("pipe_hazard_fwd_ctrl: LOAD_LAT must be < DEPTH-1");
  end
  if (!addr_w_legal(REG_ADDR_W)) begin : g_bad_addr_w
    $error("pipe_hazard_fwd_ctrl: REG_ADDR_W out of range");
  end

  logic                 hit_a, hit_b, load_a, load_b;
  logic [FWD_SEL_W-1:0] idx_a, idx_b;
  logic                 used_a, used_b, need_stall_a, need_stall_b, hazard;
  logic                 flush;
  sb_entry_t            push;

  logic [FWD_SEL_W-1:0] fwd_sel_a_q, fwd_sel_a_d, fwd_sel_b_q, fwd_sel_b_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]     freeze_cnt_q, freeze_cnt_d;

  pipe_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .DEPTH      (DEPTH)
  ) u_sb (
    .clk_i    (clk),
    .rst_i    (rst),
    .adv_i    (!mem_busy),
    .push_i   (push),
    .src_a_i  (id_src1),
    .src_b_i  (id_src2),
    .hit_a_o  (hit_a),
    .idx_a_o  (idx_a),
    .load_a_o (load_a),
    .hit_b_o  (hit_b),
    .idx_b_o  (idx_b),
    .load_b_o (load_b)
  );

  assign used_a = id_valid && id_use_src1 && hit_a;
  assign used_b = id_valid && id_use_src2 && hit_b;

  // With forwarding, only a load not yet past LOAD_LAT blocks; the result
  // lands at entry k+1 once the consumer reaches EXE.
  always_comb begin
    need_stall_a = 1'b0;
    need_stall_b = 1'b0;
    if (FWD_EN) begin
      need_stall_a = used_a && load_a && ((int'(idx_a) + 1) <= int'(LOAD_LAT));
      need_stall_b = used_b && load_b && ((int'(idx_b) + 1) <= int'(LOAD_LAT));
    end else begin
      need_stall_a = used_a;
      need_stall_b = used_b;
    end
  end

  assign hazard       = need_stall_a || need_stall_b;
  assign freeze_all   = mem_busy;
  assign flush        = !mem_busy && br_taken;
  assign flush_if_id  = flush;
  assign flush_id_exe = flush;
  assign stall_if     = !mem_busy && !br_taken && hazard;

  always_comb begin
    push         = '0;
    push.valid   = id_valid && !stall_if && !br_taken;
    push.wb_en   = id_wb_en;
    push.dest    = SB_DEST_W'(id_dest);
    push.is_load = id_mem_r_en;
  end

  always_comb begin
    fwd_sel_a_d = fwd_sel_a_q;
    fwd_sel_b_d = fwd_sel_b_q;
    if (!mem_busy) begin
      fwd_sel_a_d = FWD_SEL_W'(FWD_RF);
      fwd_sel_b_d = FWD_SEL_W'(FWD_RF);
      if (FWD_EN && id_valid && !stall_if && !br_taken) begin
        if (used_a) fwd_sel_a_d = idx_a + 1'b1;
        if (used_b) fwd_sel_b_d = idx_b + 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    if (stall_if && (stall_cnt_q != '1))   stall_cnt_d  = stall_cnt_q + 1'b1;
    if (flush && (flush_cnt_q != '1))      flush_cnt_d  = flush_cnt_q + 1'b1;
    if (mem_busy && (freeze_cnt_q != '1))  freeze_cnt_d = freeze_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_sel_a_q  <= '0;
      fwd_sel_b_q  <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      fwd_sel_a_q  <= fwd_sel_a_d;
      fwd_sel_b_q  <= fwd_sel_b_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign fwd_sel_a  = fwd_sel_a_q;
  assign fwd_sel_b  = fwd_sel_b_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_fwd_ctrl.sv
// Directed bench for pipe_hazard_fwd_ctrl. Four instances share one stimulus
// stream; each test checks only the instance whose parameters it targets.
module tb_pipe_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_src1, id_use_src2, id_wb_en, id_mem_r_en;
  logic [3:0] id_src1, id_src2, id_dest;
  logic       br_taken, mem_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // default parameters
  logic        d_frz, d_stl, d_fif, d_fie;
  logic [1:0]  d_sa, d_sb;
  logic [31:0] d_sc, d_fc, d_zc;
  // LOAD_LAT=0, 2-bit counters
  logic        l_frz, l_stl, l_fif, l_fie;
  logic [1:0]  l_sa, l_sb;
  logic [1:0]  l_sc, l_fc, l_zc;
  // FWD_EN=0
  logic        n_frz, n_stl, n_fif, n_fie;
  logic [1:0]  n_sa, n_sb;
  logic [31:0] n_sc, n_fc, n_zc;
  // DEPTH=5
  logic        f_frz, f_stl, f_fif, f_fie;
  logic [2:0]  f_sa, f_sb;
  logic [31:0] f_sc, f_fc, f_zc;

  pipe_hazard_fwd_ctrl u_def (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_wb_en(id_wb_en),
    .id_dest(id_dest), .id_mem_r_en(id_mem_r_en), .br_taken(br_taken), .mem_busy(mem_busy),
    .freeze_all(d_frz), .stall_if(d_stl), .flush_if_id(d_fif), .flush_id_exe(d_fie),
    .fwd_sel_a(d_sa), .fwd_sel_b(d_sb), .stall_cnt(d_sc), .flush_cnt(d_fc), .freeze_cnt(d_zc)
  );

  pipe_hazard_fwd_ctrl #(.LOAD_LAT(0), .CNT_W(2)) u_ll0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_wb_en(id_wb_en),
    .id_dest(id_dest), .id_mem_r_en(id_mem_r_en), .br_taken(br_taken), .mem_busy(mem_busy),
    .freeze_all(l_frz), .stall_if(l_stl), .flush_if_id(l_fif), .flush_id_exe(l_fie),
    .fwd_sel_a(l_sa), .fwd_sel_b(l_sb), .stall_cnt(l_sc), .flush_cnt(l_fc), .freeze_cnt(l_zc)
  );

  pipe_hazard_fwd_ctrl #(.FWD_EN(1'b0)) u_nf (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_wb_en(id_wb_en),
    .id_dest(id_dest), .id_mem_r_en(id_mem_r_en), .br_taken(br_taken), .mem_busy(mem_busy),
    .freeze_all(n_frz), .stall_if(n_stl), .flush_if_id(n_fif), .flush_id_exe(n_fie),
    .fwd_sel_a(n_sa), .fwd_sel_b(n_sb), .stall_cnt(n_sc), .flush_cnt(n_fc), .freeze_cnt(n_zc)
  );

  pipe_hazard_fwd_ctrl #(.DEPTH(5)) u_d5 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_wb_en(id_wb_en),
    .id_dest(id_dest), .id_mem_r_en(id_mem_r_en), .br_taken(br_taken), .mem_busy(mem_busy),
    .freeze_all(f_frz), .stall_if(f_stl), .flush_if_id(f_fif), .flush_id_exe(f_fie),
    .fwd_sel_a(f_sa), .fwd_sel_b(f_sb), .stall_cnt(f_sc), .flush_cnt(f_fc), .freeze_cnt(f_zc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    id_valid    = 1'b0;
    id_src1     = '0;
    id_src2     = '0;
    id_use_src1 = 1'b0;
    id_use_src2 = 1'b0;
    id_wb_en    = 1'b0;
    id_dest     = '0;
    id_mem_r_en = 1'b0;
    br_taken    = 1'b0;
    mem_busy    = 1'b0;
  endtask

  // Writer of rd reading rs1/rs2 (when u1/u2 set); ld marks a load.
  task automatic instr(input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic u1, input logic u2, input logic ld);
    id_valid    = 1'b1;
    id_wb_en    = 1'b1;
    id_dest     = rd;
    id_src1     = rs1;
    id_src2     = rs2;
    id_use_src1 = u1;
    id_use_src2 = u2;
    id_mem_r_en = ld;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    settle();
    check("rst_fwd_a", 32'(d_sa), 0);
    check("rst_fwd_b", 32'(d_sb), 0);
    check("rst_stall_cnt", d_sc, 0);
    check("rst_freeze", 32'(d_frz), 0);
    check("rst_stall", 32'(d_stl), 0);
    check("rst_flush", 32'(d_fif), 0);

    // 1: back-to-back ALU dependency, then one instruction in between
    instr(4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0); settle();
    check("t1_first_nostall", 32'(d_stl), 0);
    tick();
    instr(4'd2, 4'd1, 4'd3, 1'b1, 1'b1, 1'b0); settle();
    check("t1_b2b_nostall", 32'(d_stl), 0);
    tick();
    check("t1_b2b_fwd_a", 32'(d_sa), 1);
    check("t1_b2b_fwd_b", 32'(d_sb), 0);
    instr(4'd6, 4'd8, 4'd9, 1'b1, 1'b1, 1'b0); tick();
    instr(4'd7, 4'd8, 4'd9, 1'b1, 1'b1, 1'b0); tick();
    instr(4'd2, 4'd6, 4'd3, 1'b1, 1'b1, 1'b0); settle();
    check("t1_gap_nostall", 32'(d_stl), 0);
    tick();
    check("t1_gap_fwd_a", 32'(d_sa), 2);

    // 2: load-use
    do_reset();
    instr(4'd4, 4'd8, 4'd9, 1'b1, 1'b0, 1'b1); tick();
    instr(4'd5, 4'd4, 4'd0, 1'b1, 1'b0, 1'b0); settle();
    check("t2_stall", 32'(d_stl), 1);
    check("t2_ll0_nostall", 32'(l_stl), 0);
    tick();
    check("t2_stall_fwd_a", 32'(d_sa), 0);
    check("t2_ll0_fwd_a", 32'(l_sa), 1);
    settle();
    check("t2_stall_released", 32'(d_stl), 0);
    tick();
    check("t2_fwd_a", 32'(d_sa), 2);
    check("t2_stall_cnt", d_sc, 1);

    // 3: stall-only mode
    do_reset();
    settle();
    check("t3_cnt_cleared", d_sc, 0);
    instr(4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0); tick();
    instr(4'd2, 4'd1, 4'd1, 1'b1, 1'b1, 1'b0); settle();
    check("t3_stall_c1", 32'(n_stl), 1);
    tick();
    check("t3_fwd_c1", 32'(n_sa), 0);
    settle();
    check("t3_stall_c2", 32'(n_stl), 1);
    tick();
    check("t3_fwd_c2", 32'(n_sa), 0);
    settle();
    check("t3_issue_c3", 32'(n_stl), 0);
    tick();
    check("t3_fwd_a", 32'(n_sa), 0);
    check("t3_fwd_b", 32'(n_sb), 0);
    check("t3_stall_cnt", n_sc, 2);
    instr(4'd3, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0); settle();
    check("t3_issued_dep_stall", 32'(n_stl), 1);

    // 4: branch with pending load-use
    do_reset();
    instr(4'd4, 4'd8, 4'd9, 1'b1, 1'b0, 1'b1); tick();
    instr(4'd5, 4'd4, 4'd0, 1'b1, 1'b0, 1'b0);
    br_taken = 1'b1; settle();
    check("t4_flush_if_id", 32'(d_fif), 1);
    check("t4_flush_id_exe", 32'(d_fie), 1);
    check("t4_stall_suppr", 32'(d_stl), 0);
    tick();
    br_taken = 1'b0;
    instr(4'd6, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0); settle();
    check("t4_after_nostall", 32'(d_stl), 0);
    check("t4_after_noflush", 32'(d_fif), 0);
    tick();
    check("t4_bubble_fwd_a", 32'(d_sa), 0);
    check("t4_flush_cnt", d_fc, 1);
    check("t4_stall_cnt", d_sc, 0);

    // 5: memory wait with a taken branch held in EXE
    do_reset();
    instr(4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0); tick();
    instr(4'd2, 4'd1, 4'd3, 1'b1, 1'b1, 1'b0);
    mem_busy = 1'b1;
    br_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t5_freeze", 32'(d_frz), 1);
      check("t5_no_flush", 32'(d_fif), 0);
      check("t5_no_stall", 32'(d_stl), 0);
      tick();
    end
    mem_busy = 1'b0; settle();
    check("t5_flush_after", 32'(d_fie), 1);
    check("t5_unfrozen", 32'(d_frz), 0);
    tick();
    check("t5_freeze_cnt", d_zc, 3);
    check("t5_flush_cnt", d_fc, 1);
    check("t5_ll0_freeze_cnt", 32'(l_zc), 3);
    br_taken = 1'b0;
    instr(4'd3, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0); settle();
    check("t5_dep_nostall", 32'(d_stl), 0);
    tick();
    check("t5_sb_held_fwd_a", 32'(d_sa), 2);
    idle();
    mem_busy = 1'b1;
    tick();
    tick();
    mem_busy = 1'b0;
    check("t5_freeze_cnt_more", d_zc, 5);
    check("t5_ll0_freeze_sat", 32'(l_zc), 3);

    // 6: DEPTH=5 distance-3 forwarding, then reset mid-stream
    do_reset();
    instr(4'd7, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); tick();
    instr(4'd8, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); tick();
    instr(4'd9, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); tick();
    instr(4'd10, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0); settle();
    check("t6_nostall", 32'(f_stl), 0);
    tick();
    check("t6_fwd_a", 32'(f_sa), 3);
    instr(4'd11, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1); tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    instr(4'd12, 4'd11, 4'd0, 1'b1, 1'b0, 1'b0); settle();
    check("t6_post_rst_nostall", 32'(f_stl), 0);
    tick();
    check("t6_post_rst_fwd_a", 32'(f_sa), 0);
    check("t6_post_rst_stall_cnt", f_sc, 0);

    idle();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
